// File: rtl/spi_bus_arb.sv
// rtl/spi_bus_arb.sv - round-robin arbiter sharing one SPI master among three requesters
// Routes the master's slave select to the granted target and enforces an idle gap between transactions.
module spi_bus_arb #(
    parameter int GAP_CYCLES = 4,
    parameter int TO_CYCLES  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  req_i,
    input  logic [15:0] cmd0_i,
    input  logic [15:0] cmd1_i,
    input  logic [15:0] cmd2_i,
    input  logic [2:0]  tgt0_i,
    input  logic [2:0]  tgt1_i,
    input  logic [2:0]  tgt2_i,
    output logic [2:0]  gnt_o,
    output logic [2:0]  done_o,
    output logic [15:0] rdata_o,
    output logic        err_o,
    input  logic        clr_err_i,
    output logic        spi_wrt_o,
    output logic [15:0] spi_cmd_o,
    input  logic        spi_done_i,
    input  logic [15:0] spi_rd_i,
    input  logic        spi_ss_n_i,
    output logic        ch1_ss_n_o,
    output logic        ch2_ss_n_o,
    output logic        ch3_ss_n_o,
    output logic        trig_ss_n_o,
    output logic        eep_ss_n_o
);

    localparam int TO_W  = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TO_CYCLES > 0) ? TO_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [2:0]         done_q, done_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               wrt_q, wrt_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [2:0]         tgt_q, tgt_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]    busy_cnt_q, busy_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [1:0]         win;
    logic               win_valid;
    logic [15:0]        win_cmd;
    logic [2:0]         win_tgt;
    logic               err_event;
    logic [4:0]         ss_n;

    // Scan from the farthest candidate back to rr_ptr so the nearest requester is the last assignment.
    always_comb begin
        win       = 2'd0;
        win_valid = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (req_i[(int'(rr_ptr_q) + k) % 3]) begin
                win       = 2'((int'(rr_ptr_q) + k) % 3);
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        case (win)
            2'd1:    begin win_cmd = cmd1_i; win_tgt = tgt1_i; end
            2'd2:    begin win_cmd = cmd2_i; win_tgt = tgt2_i; end
            default: begin win_cmd = cmd0_i; win_tgt = tgt0_i; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = 3'b000;
        rdata_d    = rdata_q;
        wrt_d      = 1'b0;
        cmd_d      = cmd_q;
        tgt_d      = tgt_q;
        rr_ptr_d   = rr_ptr_q;
        busy_cnt_d = busy_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        err_event  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    rr_ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    if (win_tgt > 3'd4) begin
                        done_d    = 3'b001 << win;
                        err_event = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        gnt_d      = 3'b001 << win;
                        cmd_d      = win_cmd;
                        tgt_d      = win_tgt;
                        wrt_d      = 1'b1;
                        busy_cnt_d = '0;
                        state_d    = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (spi_done_i || busy_cnt_q == TO_LAST) begin
                    done_d    = gnt_q;
                    gnt_d     = 3'b000;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    if (spi_done_i) begin
                        rdata_d = spi_rd_i;
                    end else begin
                        rdata_d   = 16'hFFFF;
                        err_event = 1'b1;
                    end
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh error outranks a clear in the same cycle.
        err_d = (err_q && !clr_err_i) || err_event;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'b000;
            done_q     <= 3'b000;
            rdata_q    <= 16'h0000;
            err_q      <= 1'b0;
            wrt_q      <= 1'b0;
            cmd_q      <= 16'h0000;
            tgt_q      <= 3'd0;
            rr_ptr_q   <= 2'd0;
            busy_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wrt_q      <= wrt_d;
            cmd_q      <= cmd_d;
            tgt_q      <= tgt_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_cnt_q <= busy_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        ss_n = 5'b11111;
        if (state_q == ST_BUSY) begin
            case (tgt_q)
                3'd0:    ss_n[0] = spi_ss_n_i;
                3'd1:    ss_n[1] = spi_ss_n_i;
                3'd2:    ss_n[2] = spi_ss_n_i;
                3'd3:    ss_n[3] = spi_ss_n_i;
                3'd4:    ss_n[4] = spi_ss_n_i;
                default: ss_n = 5'b11111;
            endcase
        end
    end

    assign ch1_ss_n_o  = ss_n[0];
    assign ch2_ss_n_o  = ss_n[1];
    assign ch3_ss_n_o  = ss_n[2];
    assign trig_ss_n_o = ss_n[3];
    assign eep_ss_n_o  = ss_n[4];

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign spi_wrt_o = wrt_q;
    assign spi_cmd_o = cmd_q;

endmodule

// File: tb/tb_spi_bus_arb.sv
// tb/tb_spi_bus_arb.sv - self-checking bench for spi_bus_arb
// A transaction-level model predicts every output each cycle; directed steps add literal checks.
module tb_spi_bus_arb;

    localparam int GAP = 4;
    localparam int TO  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [15:0] cmd [3];
    logic [2:0]  tgt [3];
    logic        clr_err = 1'b0;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd = 16'h0000;
    logic        spi_ss_n = 1'b1;

    logic [2:0]  gnt_o, done_o;
    logic [15:0] rdata_o, spi_cmd_o;
    logic        err_o, spi_wrt_o;
    logic        ch1_ss_n_o, ch2_ss_n_o, ch3_ss_n_o, trig_ss_n_o, eep_ss_n_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    spi_bus_arb #(.GAP_CYCLES(GAP), .TO_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .cmd0_i(cmd[0]), .cmd1_i(cmd[1]), .cmd2_i(cmd[2]),
        .tgt0_i(tgt[0]), .tgt1_i(tgt[1]), .tgt2_i(tgt[2]),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .clr_err_i(clr_err), .spi_wrt_o(spi_wrt_o), .spi_cmd_o(spi_cmd_o),
        .spi_done_i(spi_done), .spi_rd_i(spi_rd), .spi_ss_n_i(spi_ss_n),
        .ch1_ss_n_o(ch1_ss_n_o), .ch2_ss_n_o(ch2_ss_n_o), .ch3_ss_n_o(ch3_ss_n_o),
        .trig_ss_n_o(trig_ss_n_o), .eep_ss_n_o(eep_ss_n_o)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 transaction running, 2 enforced gap.
    int          m_phase = 0, m_owner = 0, m_tgt = 0, m_rr = 0;
    int          m_busy = 0, m_gap_left = 0;
    logic [2:0]  e_gnt = 0, e_done = 0;
    logic [15:0] e_rdata = 0, e_cmd = 0;
    logic        e_err = 0, e_wrt = 0;

    task automatic model_to_gap();
        if (GAP == 0) m_phase = 0;
        else begin m_phase = 2; m_gap_left = GAP; end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_rr = 0; m_busy = 0; m_gap_left = 0;
            e_gnt = 0; e_done = 0; e_rdata = 0; e_cmd = 0; e_err = 0; e_wrt = 0;
        end else begin
            automatic bit ev = 0;
            automatic int w = -1;
            e_done = 0; e_wrt = 0;
            if (m_phase == 0) begin
                for (int k = 0; k < 3 && w < 0; k++)
                    if (req[(m_rr + k) % 3]) w = (m_rr + k) % 3;
                if (w >= 0) begin
                    m_rr = (w + 1) % 3;
                    if (tgt[w] > 4) begin
                        e_done = 3'(1 << w); ev = 1; model_to_gap();
                    end else begin
                        m_owner = w; m_tgt = tgt[w]; e_cmd = cmd[w];
                        e_gnt = 3'(1 << w); e_wrt = 1; m_busy = 0; m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                m_busy++;
                if (spi_done) begin
                    e_rdata = spi_rd; e_done = 3'(1 << m_owner); e_gnt = 0; model_to_gap();
                end else if (m_busy == TO) begin
                    e_rdata = 16'hFFFF; e_done = 3'(1 << m_owner); e_gnt = 0; ev = 1; model_to_gap();
                end
            end else begin
                m_gap_left--;
                if (m_gap_left == 0) m_phase = 0;
            end
            if (ev) e_err = 1;
            else if (clr_err) e_err = 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            automatic logic [4:0] e_ss = 5'b11111;
            if (m_phase == 1) e_ss[m_tgt] = spi_ss_n;
            check("gnt", 32'(gnt_o), 32'(e_gnt));
            check("done", 32'(done_o), 32'(e_done));
            check("spi_wrt", 32'(spi_wrt_o), 32'(e_wrt));
            check("spi_cmd", 32'(spi_cmd_o), 32'(e_cmd));
            check("rdata", 32'(rdata_o), 32'(e_rdata));
            check("err", 32'(err_o), 32'(e_err));
            check("ss_n", 32'({eep_ss_n_o, trig_ss_n_o, ch3_ss_n_o, ch2_ss_n_o, ch1_ss_n_o}), 32'(e_ss));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_wrt(input int maxc, output int n);
        n = 0;
        while (spi_wrt_o !== 1'b1 && n < maxc) begin tick(); n++; end
        if (spi_wrt_o !== 1'b1) check("wait_wrt_bound", 32'(n), 32'(maxc + 1));
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        while (done_o === 3'b000 && n < maxc) begin tick(); n++; end
        if (done_o === 3'b000) check("wait_done_bound", 32'(n), 32'(maxc + 1));
    endtask

    task automatic finish_txn(input logic [15:0] rd);
        spi_rd = rd; spi_done = 1; tick(); spi_done = 0;
    endtask

    int n;
    int order [4];
    int last_wrt, cyc;

    initial begin
        cmd[0] = 0; cmd[1] = 0; cmd[2] = 0;
        tgt[0] = 0; tgt[1] = 0; tgt[2] = 0;
        tick(); tick();
        chk_en = 1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_rdata", 32'(rdata_o), 32'h0);
        tick(); rst = 0;

        // Single request to trig; later edits to req/cmd/tgt must not disturb it.
        cmd[0] = 16'h1234; tgt[0] = 3; req = 3'b001;
        tick();
        check("t1_gnt", 32'(gnt_o), 32'h1);
        check("t1_wrt", 32'(spi_wrt_o), 32'h1);
        check("t1_cmd", 32'(spi_cmd_o), 32'h1234);
        req = 0; cmd[0] = 16'hFFFF; tgt[0] = 0; spi_ss_n = 0;
        tick();
        check("t1_trig_ss", 32'(trig_ss_n_o), 32'h0);
        check("t1_ch1_ss", 32'(ch1_ss_n_o), 32'h1);
        tick(); spi_ss_n = 1;
        finish_txn(16'h00AB);
        check("t1_done", 32'(done_o), 32'h1);
        check("t1_rdata", 32'(rdata_o), 32'h00AB);
        req = 3'b001; tgt[0] = 1;
        wait_wrt(20, n);
        check("t1_gap_len", 32'(n), 32'(GAP + 1));

        // Reset in the middle of a transaction.
        tick(); spi_ss_n = 0;
        #1 rst = 1; #1;
        check("rst_mid_gnt", 32'(gnt_o), 32'h0);
        check("rst_mid_done", 32'(done_o), 32'h0);
        check("rst_mid_ss", 32'({eep_ss_n_o, trig_ss_n_o, ch3_ss_n_o, ch2_ss_n_o, ch1_ss_n_o}), 32'h1F);
        spi_ss_n = 1; req = 3'b100; cmd[2] = 16'hC0DE; tgt[2] = 2;
        tick(); rst = 0;
        wait_wrt(5, n);
        check("rst_first_gnt", 32'(gnt_o), 32'h4);
        req = 0; tick();
        finish_txn(16'h2222);

        // Round robin with all three requesting.
        req = 3'b111; cmd[0] = 16'hA000; cmd[1] = 16'hA001; cmd[2] = 16'hA002; tgt[1] = 4;
        cyc = 0; last_wrt = -100;
        for (int i = 0; i < 4; i++) begin
            wait_wrt(20, n);
            cyc += n;
            order[i] = (gnt_o == 3'b001) ? 0 : (gnt_o == 3'b010) ? 1 : (gnt_o == 3'b100) ? 2 : -1;
            if (i > 0) check("rr_spacing_ok", 32'(cyc - last_wrt >= GAP + 1), 32'h1);
            last_wrt = cyc;
            tick(); tick(); cyc += 2;
            finish_txn(16'(16'h3000 + i)); cyc += 1;
        end
        req = 0;
        check("rr_0", 32'(order[0]), 32'd0);
        check("rr_1", 32'(order[1]), 32'd1);
        check("rr_2", 32'(order[2]), 32'd2);
        check("rr_3", 32'(order[3]), 32'd0);

        // Timeout on the EEPROM path.
        req = 3'b010; tgt[1] = 4;
        wait_wrt(20, n);
        req = 0; spi_ss_n = 0;
        wait_done(TO + 50, n);
        spi_ss_n = 1;
        check("to_len", 32'(n), 32'(TO));
        check("to_done", 32'(done_o), 32'h2);
        check("to_rdata", 32'(rdata_o), 32'hFFFF);
        check("to_err", 32'(err_o), 32'h1);
        clr_err = 1; tick(); clr_err = 0;
        check("to_clr", 32'(err_o), 32'h0);

        // Invalid target, then clear colliding with a new invalid target.
        repeat (GAP + 1) tick();
        req = 3'b001; tgt[0] = 6;
        tick();
        check("inv_wrt", 32'(spi_wrt_o), 32'h0);
        check("inv_done", 32'(done_o), 32'h1);
        check("inv_err", 32'(err_o), 32'h1);
        req = 0;
        repeat (GAP + 1) tick();
        req = 3'b001; tgt[0] = 7; clr_err = 1;
        tick();
        clr_err = 0; req = 0;
        check("clr_vs_err", 32'(err_o), 32'h1);
        clr_err = 1; tick(); clr_err = 0;
        check("clr_after", 32'(err_o), 32'h0);

        // spi_done lands in exactly the timeout cycle.
        repeat (GAP + 1) tick();
        req = 3'b001; tgt[0] = 0; cmd[0] = 16'hABCD;
        wait_wrt(20, n);
        req = 0;
        n = 0;
        while (m_busy != TO - 1 && n < TO + 10) begin tick(); n++; end
        spi_rd = 16'h5A5A; spi_done = 1;
        tick(); spi_done = 0;
        check("prec_done", 32'(done_o), 32'h1);
        check("prec_rdata", 32'(rdata_o), 32'h5A5A);
        check("prec_err", 32'(err_o), 32'h0);

        // spi_done while idle is ignored.
        repeat (GAP + 2) tick();
        spi_rd = 16'h1111; spi_done = 1; tick(); spi_done = 0;
        check("idle_done_rdata", 32'(rdata_o), 32'h5A5A);
        check("idle_done_done", 32'(done_o), 32'h0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_bus_arb.md
SPI_BUS_ARB -- requirements
Module: spi_bus_arb

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4: number of idle clk cycles enforced between consecutive SPI transactions.
REQ-002 SHALL have parameter TO_CYCLES, default 1024: number of clk cycles in BUSY without spi_done before a timeout is declared.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  3  per-requester request: bit0 command processor (gain/trigger pots), bit1 EEPROM calibration engine, bit2 spare.
REQ-006 cmd0, cmd1, cmd2  input  16 each  SPI command word of each requester.
REQ-007 tgt0, tgt1, tgt2  input  3 each  slave target of each requester: 0 ch1, 1 ch2, 2 ch3, 3 trig, 4 EEP; 5-7 invalid.
REQ-008 gnt  output  3  one-hot grant, held for the whole transaction.
REQ-009 done  output  3  one-cycle completion pulse to the owning requester.
REQ-010 rdata  output  16  SPI read data of the last completed transaction.
REQ-011 err  output  1  sticky error flag: timeout or invalid target.
REQ-012 clr_err  input  1  synchronous clear of err.
REQ-013 spi_wrt  output  1  one-cycle start pulse to the SPI master.
REQ-014 spi_cmd  output  16  command word to the SPI master.
REQ-015 spi_done  input  1  SPI master transaction-complete pulse.
REQ-016 spi_rd  input  16  SPI master read data.
REQ-017 spi_ss_n  input  1  SPI master's single slave select.
REQ-018 ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n  output  1 each  routed slave selects.

Function
REQ-019 States SHALL be IDLE, BUSY and GAP.
REQ-020 In IDLE with any req bit set, the block SHALL select a winner round-robin, starting at rr_ptr and searching upward modulo 3.
REQ-021 On the grant edge the block SHALL register gnt one-hot, latch spi_cmd and the target from the winner, pulse spi_wrt for exactly that one cycle, set rr_ptr to (winner+1) mod 3, and enter BUSY.
REQ-022 The latency from req sampled in IDLE to spi_wrt high SHALL be 1 clk.
REQ-023 If the winner's target is invalid, the block SHALL NOT pulse spi_wrt; it SHALL pulse done for that requester on the grant edge, set err, leave rdata unchanged, and enter GAP.
REQ-024 In BUSY, the selected *_ss_n output SHALL equal spi_ss_n; all other *_ss_n outputs SHALL be 1.
REQ-025 Outside BUSY, all *_ss_n outputs SHALL be 1.
REQ-026 On spi_done in BUSY, the block SHALL, on the next edge: register rdata from spi_rd, pulse done for the owner for one cycle, clear gnt, and enter GAP.
REQ-027 The BUSY cycle counter SHALL reach TO_CYCLES only if spi_done is absent. When it does, the block SHALL set err, drive rdata to 16'hFFFF, pulse done, clear gnt, and enter GAP.
REQ-028 If spi_done and the timeout occur in the same cycle, spi_done SHALL take precedence.
REQ-029 GAP SHALL last GAP_CYCLES cycles and then return to IDLE; with GAP_CYCLES=0, the block SHALL go directly to IDLE.
REQ-030 Deassertion of req during BUSY or GAP SHALL be ignored; the transaction SHALL complete normally.
REQ-031 Changes to cmdX or tgtX after the grant SHALL have no effect on the transaction.
REQ-032 spi_done received outside BUSY SHALL be ignored.
REQ-033 If clr_err and a new error event occur in the same cycle, the error SHALL win and err SHALL remain 1.
REQ-034 No two gnt or done bits SHALL ever be high simultaneously.

Reset
REQ-035 On rst high the block SHALL asynchronously force: state=IDLE, gnt=0, done=0, spi_wrt=0, spi_cmd=0, rdata=0, err=0, rr_ptr=0, counters=0, and all *_ss_n outputs=1.
REQ-036 A reset asserted mid-transaction SHALL abort the transaction with no done pulse.
REQ-037 After reset, the first grant SHALL go to the lowest set req bit.

Verification
REQ-038 Single request: req=001, cmd0=16'h1234, tgt0=3 -> next cycle gnt=001, spi_wrt=1, spi_cmd=16'h1234. During BUSY, trig_ss_n follows spi_ss_n and the other four selects stay 1. On spi_done with spi_rd=16'h00AB -> done=001 and rdata=16'h00AB. Then 4 GAP cycles, then IDLE.
REQ-039 Round-robin: req=111 held continuously -> grant order 0,1,2,0, with at least GAP_CYCLES+1 cycles between spi_wrt pulses.
REQ-040 Timeout: req=010, tgt1=4, spi_done never asserted -> after 1024 BUSY cycles, done=010, rdata=16'hFFFF, err=1. Then clr_err -> err=0.
REQ-041 Invalid target: req=001, tgt0=6 -> no spi_wrt, done=001 on the grant edge, err=1, all *_ss_n stay 1.
REQ-042 Reset mid-operation: assert rst during BUSY -> all outputs reach reset values immediately, with no done pulse. Then req=100 -> grant to requester 2.
REQ-043 Precedence and edges: spi_done coincident with the timeout cycle -> rdata=spi_rd and err unchanged. spi_done pulsed in IDLE -> no effect.
